// File: rtl/gray_updown_nbits.sv
// gray_updown_nbits: parametrised up/down Gray-code counter.
// It supports a synchronous parallel load, optional saturation at both ends
// of the range, and a binary mirror of the count. gray_out is kept in its own
// register, so it never toggles through intermediate codes on an update.
module gray_updown_nbits #(
    parameter int N        = 5,
    parameter bit SATURATE = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clk_en,
    input  logic         up_dn,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] gray_out,
    output logic [N-1:0] bin_out,
    output logic         wrap,
    output logic         at_limit
);

    logic [N-1:0] cnt;
    logic [N-1:0] next_cnt;
    logic         next_wrap;
    logic         cnt_is_max;
    logic         cnt_is_min;

    assign cnt_is_max = (cnt == '1);
    assign cnt_is_min = (cnt == '0);

    // Next-count selection: load beats count enable; the ends of the range either wrap or hold
    always_comb begin
        next_cnt  = cnt;
        next_wrap = 1'b0;
        if (load) begin
            next_cnt = load_val;
        end else if (clk_en) begin
            if (up_dn) begin
                if (!cnt_is_max) begin
                    next_cnt = cnt + N'(1);
                end else if (!SATURATE) begin
                    next_cnt  = '0;
                    next_wrap = 1'b1;
                end
            end else begin
                if (!cnt_is_min) begin
                    next_cnt = cnt - N'(1);
                end else if (!SATURATE) begin
                    next_cnt  = '1;
                    next_wrap = 1'b1;
                end
            end
        end
    end

    // Binary count, Gray code and wrap pulse all register on the same edge; reset wins over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            gray_out <= '0;
            wrap     <= 1'b0;
        end else begin
            cnt      <= next_cnt;
            gray_out <= next_cnt ^ (next_cnt >> 1);
            wrap     <= next_wrap;
        end
    end

    assign bin_out  = cnt;
    assign at_limit = up_dn ? cnt_is_max : cnt_is_min;

endmodule

// File: tb/tb_gray_updown_nbits.sv
// tb_gray_updown_nbits: wrapping and saturating instances driven in lockstep.
// An integer model is checked against both instances on every cycle, and
// hand-computed literals pin the model at the key points.
module tb_gray_updown_nbits;

    localparam int N   = 5;
    localparam int MAX = (1 << N) - 1;

    logic         clk;
    logic         rst;
    logic         clk_en;
    logic         up_dn;
    logic         load;
    logic [N-1:0] load_val;

    logic [N-1:0] gray0, bin0, gray1, bin1;
    logic         wrap0, lim0, wrap1, lim1;

    int errors = 0;
    int checks = 0;

    gray_updown_nbits #(.N(N), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .clk_en(clk_en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .gray_out(gray0), .bin_out(bin0), .wrap(wrap0),
        .at_limit(lim0)
    );

    gray_updown_nbits #(.N(N), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .clk_en(clk_en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .gray_out(gray1), .bin_out(bin1), .wrap(wrap1),
        .at_limit(lim1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: plain integer counts, one per SATURATE setting
    int m0 = 0, m1 = 0;
    bit mw0 = 0, mw1 = 0;
    bit valid = 0;
    bit moved0 = 0, moved1 = 0;

    always @(posedge clk) begin
        moved0 = 0;
        moved1 = 0;
        if (rst) begin
            m0 = 0; m1 = 0; mw0 = 0; mw1 = 0; valid = 1;
        end else if (load) begin
            m0 = int'(load_val); m1 = int'(load_val); mw0 = 0; mw1 = 0;
        end else if (clk_en) begin
            moved0 = 1;
            mw0 = 0;
            mw1 = 0;
            if (up_dn) begin
                if (m0 == MAX) begin m0 = 0; mw0 = 1; end else m0 = m0 + 1;
                if (m1 != MAX) begin m1 = m1 + 1; moved1 = 1; end
            end else begin
                if (m0 == 0) begin m0 = MAX; mw0 = 1; end else m0 = m0 - 1;
                if (m1 != 0) begin m1 = m1 - 1; moved1 = 1; end
            end
        end else begin
            mw0 = 0; mw1 = 0;
        end
    end

    // Compare process: sampled on the falling edge, away from the active edge
    logic [N-1:0] prev_g0, prev_g1;
    bit prev_ok = 0;
    always @(negedge clk) begin
        if (valid) begin
            chk("w.bin",   32'(bin0),  32'(m0));
            chk("w.gray",  32'(gray0), 32'(m0 ^ (m0 >> 1)));
            chk("w.wrap",  32'(wrap0), 32'(mw0));
            chk("w.limit", 32'(lim0),  32'(up_dn ? (m0 == MAX) : (m0 == 0)));
            chk("s.bin",   32'(bin1),  32'(m1));
            chk("s.gray",  32'(gray1), 32'(m1 ^ (m1 >> 1)));
            chk("s.wrap",  32'(wrap1), 32'(mw1));
            chk("s.limit", 32'(lim1),  32'(up_dn ? (m1 == MAX) : (m1 == 0)));
            if (prev_ok && moved0)
                chk("w.hamming", 32'($countones(gray0 ^ prev_g0)), 32'd1);
            if (prev_ok && moved1)
                chk("s.hamming", 32'($countones(gray1 ^ prev_g1)), 32'd1);
            prev_g0 = gray0;
            prev_g1 = gray1;
            prev_ok = 1;
        end
    end

    task automatic step(input logic r, input logic en, input logic up,
                        input logic ld, input logic [N-1:0] lv);
        rst = r; clk_en = en; up_dn = up; load = ld; load_val = lv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b1; up_dn = 1'b1; load = 1'b1; load_val = 5'b10101;

        // Reset overrides load and enable
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b1, 5'b10101);
            chk("rst.gray", 32'(gray0), 32'd0);
            chk("rst.bin",  32'(bin0),  32'd0);
            chk("rst.wrap", 32'(wrap0), 32'd0);
        end

        // Count up 32 edges: wrap back to 0 exactly once
        for (int i = 1; i <= 32; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, '0);
            if (i == 1)  chk("up.g1",  32'(gray0), 32'b00001);
            if (i == 2)  chk("up.g2",  32'(gray0), 32'b00011);
            if (i == 3)  chk("up.g3",  32'(gray0), 32'b00010);
            if (i == 31) chk("up.g31", 32'(gray0), 32'b10000);
            if (i < 32)  chk("up.nowrap", 32'(wrap0), 32'd0);
        end
        chk("up.wrapbin",  32'(bin0),  32'd0);
        chk("up.wrapgray", 32'(gray0), 32'd0);
        chk("up.wrap",     32'(wrap0), 32'd1);
        chk("sat.top",     32'(bin1),  32'd31);
        chk("sat.nowrap",  32'(wrap1), 32'd0);

        // Count down through 0
        step(1'b1, 1'b0, 1'b1, 1'b0, '0);
        rst = 1'b0; clk_en = 1'b1; up_dn = 1'b0; load = 1'b0;
        #1;
        chk("dn.limit_before", 32'(lim0), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        chk("dn.bin",  32'(bin0),  32'b11111);
        chk("dn.gray", 32'(gray0), 32'b10000);
        chk("dn.wrap", 32'(wrap0), 32'd1);
        chk("dn.satbin", 32'(bin1), 32'd0);

        // Load wins over enable, then hold with enable low
        step(1'b0, 1'b1, 1'b1, 1'b1, 5'b01101);
        chk("ld.bin",  32'(bin0),  32'b01101);
        chk("ld.gray", 32'(gray0), 32'b01011);
        chk("ld.wrap", 32'(wrap0), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 5'b11111);
            chk("hold.bin",  32'(bin0),  32'b01101);
            chk("hold.gray", 32'(gray0), 32'b01011);
        end

        // Saturation at the top
        step(1'b0, 1'b0, 1'b1, 1'b1, 5'b11110);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, '0);
            chk("sat.bin",   32'(bin1),  32'b11111);
            chk("sat.wrap",  32'(wrap1), 32'd0);
            chk("sat.limit", 32'(lim1),  32'd1);
        end

        // Mid-count reset together with load
        step(1'b0, 1'b0, 1'b1, 1'b1, 5'b01000);
        step(1'b0, 1'b1, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, 1'b0, '0);
        chk("mid.bin", 32'(bin0), 32'b01010);
        step(1'b1, 1'b1, 1'b1, 1'b1, 5'b00111);
        chk("mid.rstbin",  32'(bin0),  32'd0);
        chk("mid.rstgray", 32'(gray0), 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, '0);
        chk("mid.resume", 32'(bin0), 32'b00001);

        // Direction changes, gaps in enable, and a load in the middle
        for (int i = 0; i < 48; i++) begin
            step(1'b0, logic'((i % 5) != 0), logic'(((i >> 2) & 1) == 1),
                 logic'(i == 17), 5'b00010);
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gray_updown_nbits.md
# gray_updown_nbits

Parametrised N-bit Gray-code counter that succeeds the fixed up-only Gray counter. It adds up/down counting, synchronous parallel load, optional saturation instead of wrap-around, and status flags. It provides a binary mirror of the count, so downstream logic does not need its own Gray-to-binary converter. It sits behind a clock-enable strobe, typically a slow tick from a prescaler, and drives LEDs or a cross-domain pointer.

## Interface

Parameters:
- N, default 5: counter width in bits; legal range 2..32.
- SATURATE, default 0: 0 = wrap at the ends of the range; 1 = hold at the ends.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, synchronous, active-high; overrides every other input.
- clk_en  input  1  count enable, sampled on the rising edge of clk.
- up_dn  input  1  count direction: 1 = up, 0 = down.
- load  input  1  synchronous parallel load strobe.
- load_val  input  N  binary value to load.
- gray_out  output  N  registered Gray code of the count.
- bin_out  output  N  registered binary count.
- wrap  output  1  registered one-cycle pulse on a wrap-around step.
- at_limit  output  1  combinational: the count is at the terminal value for the current up_dn.

## Operation

- Internal state is the binary register cnt, which drives bin_out.
- gray_out is a separate register, loaded each edge with next_cnt ^ (next_cnt >> 1).
  - gray_out is therefore never decoded combinationally from bin_out and is glitch-free.
- Priority per rising edge: rst > load > clk_en > hold.
- rst=1:
  - cnt, gray_out and wrap go to 0.
- load=1 (rst=0):
  - cnt ← load_val and gray_out ← gray(load_val); wrap ← 0.
  - clk_en and up_dn are ignored; load acts even when clk_en=0.
- clk_en=1, load=0, up_dn=1:
  - cnt < 2^N−1: cnt ← cnt+1, wrap ← 0.
  - cnt = 2^N−1 with SATURATE=0: cnt ← 0, wrap ← 1.
  - cnt = 2^N−1 with SATURATE=1: cnt holds, wrap ← 0.
- clk_en=1, load=0, up_dn=0:
  - cnt > 0: cnt ← cnt−1, wrap ← 0.
  - cnt = 0 with SATURATE=0: cnt ← 2^N−1, wrap ← 1.
  - cnt = 0 with SATURATE=1: cnt holds, wrap ← 0.
- clk_en=0, load=0:
  - cnt and gray_out hold; wrap ← 0.
- at_limit = (up_dn & cnt==2^N−1) | (~up_dn & cnt==0). It follows up_dn combinationally in the same cycle.
- Arithmetic is modulo 2^N on N bits; there is no carry-out port.
- Gray property: every counting step, including wrap, changes exactly one bit of gray_out.
  - A load may change any number of bits.
  - A held or saturated step changes no bits.

## Timing

- Reset values: gray_out = 0, bin_out = 0, wrap = 0.
- at_limit after reset: 1 if up_dn=0, else 0.
- Latency: inputs sampled at edge k appear on gray_out, bin_out and wrap after edge k (one cycle).
- wrap is high for exactly the cycle in which the wrapped value is presented.
- A continuous clk_en=1 across a wrap gives one single-cycle pulse per wrap.
- gray_out and bin_out always update on the same edge and always satisfy gray_out == bin_out ^ (bin_out >> 1).
- Direction change (up_dn toggled between enabled edges) takes effect on the next enabled edge; there is no dead cycle.
- rst asserted mid-count: outputs read 0 after that edge regardless of load or clk_en.
  - Counting resumes from 0 on the first enabled edge after rst deasserts.

## Test plan

- Reset: hold rst=1 for 3 edges with clk_en=1 and load=1 → gray_out=00000, bin_out=00000, wrap=0 after each edge.
- Count up, N=5, SATURATE=0: clk_en=1, up_dn=1 from 0 for 32 edges.
  - gray_out sequence is 00000→00001→00011→00010→…→10000→00000.
  - wrap=1 only in the cycle showing 00000.
  - Every transition has Hamming distance 1.
- Count down through 0: from reset, up_dn=0, one enabled edge → bin_out=11111, gray_out=10000, wrap=1; at_limit was 1 before that edge.
- Load and priority:
  - load=1, load_val=01101, clk_en=1 → bin_out=01101, gray_out=01011, wrap=0.
  - Then clk_en=0 for 5 edges → outputs unchanged.
- Saturate, SATURATE=1: load 11110, count up 3 edges → bin_out 11111, 11111, 11111; wrap stays 0; at_limit=1.
- Mid-count reset: count up to 01010, assert rst for one edge together with load=1, load_val=00111 → outputs 0; next enabled up edge → bin_out=00001.
